pattern_event_logger: RTL and testbench

Downstream consumer of the serial pattern detector's 2-bit match output. Each clock it samples the match code and counts "111" and "001" detections in saturating counters. It also logs every detection as a timestamped record in a small FIFO, which a reader drains through a valid/ready handshake. Drops and illegal codes raise sticky status flags.

---
 rtl/pattern_event_logger_if.sv | 21 ++
 rtl/pattern_event_logger.sv | 138 +++++++++++++
 tb/tb_pattern_event_logger.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_event_logger_if.sv
// Read-side handshake for the pattern event logger: the logger presents the
// head record with a valid flag, and the reader returns ready.
interface pattern_event_logger_if #(
    parameter int TS_W = 6
);
    logic            ev_valid;
    logic            ev_ready;
    logic [TS_W:0]   ev_data;

    modport master (
        output ev_valid,
        output ev_data,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_data,
        output ev_ready
    );
endinterface

// File: rtl/pattern_event_logger.sv
// Counts "111"/"001" detections from the serial pattern detector and logs each
// one as a timestamped record in a small FIFO drained over a valid/ready port.
module pattern_event_logger #(
    parameter int CNT_W = 8,
    parameter int TS_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [1:0]        match,
    input  logic              enable,
    input  logic              clear,
    output logic [CNT_W-1:0]  cnt111,
    output logic [CNT_W-1:0]  cnt001,
    output logic              overflow,
    output logic              illegal,
    pattern_event_logger_if.master ev
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam int REC_W = TS_W + 1;

    localparam logic [1:0] CODE_111     = 2'b10;
    localparam logic [1:0] CODE_001     = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL = 2'b11;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    logic [TS_W-1:0]  ts_p1;
    logic [CNT_W-1:0] cnt111_p1;
    logic [CNT_W-1:0] cnt001_p1;
    logic             overflow_p1;
    logic             illegal_p1;
    logic [PTR_W-1:0] wr_ptr_p1;
    logic [PTR_W-1:0] rd_ptr_p1;
    logic [OCC_W-1:0] occ_p1;
    logic [REC_W-1:0] mem_p1 [DEPTH];

    logic             vld_p0;
    logic             is111_p0;
    logic             is001_p0;
    logic             bad_p0;
    logic [REC_W-1:0] rec_p0;
    logic             full_p0;
    logic             empty_p0;
    logic             pop_p0;
    logic             push_p0;
    logic             drop_p0;

    // Stage p0: decode the sampled match code and FIFO handshake for this edge
    always_comb begin
        is111_p0 = enable && (match == CODE_111);
        is001_p0 = enable && (match == CODE_001);
        bad_p0   = enable && (match == CODE_ILLEGAL);
        vld_p0   = is111_p0 || is001_p0;
        rec_p0   = {match[1], ts_p1};
        full_p0  = (occ_p1 == OCC_W'(DEPTH));
        empty_p0 = (occ_p1 == '0);
        pop_p0   = !empty_p0 && ev.ev_ready;
        // A same-edge pop frees the slot the push needs, so a full FIFO still accepts.
        push_p0  = vld_p0 && (!full_p0 || pop_p0);
        drop_p0  = vld_p0 && full_p0 && !pop_p0;
    end

    // Stage p1: timestamp, counters, flags and FIFO pointers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ts_p1       <= '0;
            cnt111_p1   <= '0;
            cnt001_p1   <= '0;
            overflow_p1 <= 1'b0;
            illegal_p1  <= 1'b0;
            wr_ptr_p1   <= '0;
            rd_ptr_p1   <= '0;
            occ_p1      <= '0;
        end else if (clear) begin
            ts_p1       <= '0;
            cnt111_p1   <= '0;
            cnt001_p1   <= '0;
            overflow_p1 <= 1'b0;
            illegal_p1  <= 1'b0;
            wr_ptr_p1   <= '0;
            rd_ptr_p1   <= '0;
            occ_p1      <= '0;
        end else begin
            ts_p1 <= ts_p1 + TS_W'(1);
            if (is111_p0) begin
                cnt111_p1 <= sat_inc(cnt111_p1);
            end
            if (is001_p0) begin
                cnt001_p1 <= sat_inc(cnt001_p1);
            end
            if (drop_p0) begin
                overflow_p1 <= 1'b1;
            end
            if (bad_p0) begin
                illegal_p1 <= 1'b1;
            end
            if (push_p0) begin
                wr_ptr_p1 <= wr_ptr_p1 + PTR_W'(1);
            end
            if (pop_p0) begin
                rd_ptr_p1 <= rd_ptr_p1 + PTR_W'(1);
            end
            case ({push_p0, pop_p0})
                2'b10:   occ_p1 <= occ_p1 + OCC_W'(1);
                2'b01:   occ_p1 <= occ_p1 - OCC_W'(1);
                default: occ_p1 <= occ_p1;
            endcase
        end
    end

    // Record storage; clear only rewinds the pointers, stale entries are never exposed
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_p1[i] <= '0;
            end
        end else if (!clear && push_p0) begin
            mem_p1[wr_ptr_p1] <= rec_p0;
        end
    end

    // Outputs depend only on registered state
    assign cnt111      = cnt111_p1;
    assign cnt001      = cnt001_p1;
    assign overflow    = overflow_p1;
    assign illegal     = illegal_p1;
    assign ev.ev_valid = !empty_p0;
    assign ev.ev_data  = empty_p0 ? '0 : mem_p1[rd_ptr_p1];

endmodule

// File: tb/tb_pattern_event_logger.sv
// Directed self-checking bench for pattern_event_logger.
module tb_pattern_event_logger;

    localparam int CNT_W = 8;
    localparam int TS_W  = 6;
    localparam int DEPTH = 4;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       match   = 2'b00;
    logic             enable  = 1'b0;
    logic             clear   = 1'b0;
    logic [CNT_W-1:0] cnt111;
    logic [CNT_W-1:0] cnt001;
    logic             overflow;
    logic             illegal;

    pattern_event_logger_if #(.TS_W(TS_W)) ev_if ();

    pattern_event_logger #(
        .CNT_W (CNT_W),
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .match    (match),
        .enable   (enable),
        .clear    (clear),
        .cnt111   (cnt111),
        .cnt001   (cnt001),
        .overflow (overflow),
        .illegal  (illegal),
        .ev       (ev_if)
    );

    always #5 clock = ~clock;

    int              checks = 0;
    int              errors = 0;
    logic [TS_W-1:0] tb_ts  = '0;
    logic [TS_W:0]   exp;

    // One clock edge; tb_ts tracks the timestamp the DUT should hold afterwards
    task automatic tick();
        if (clear) tb_ts = '0;
        else       tb_ts = tb_ts + TS_W'(1);
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        match = 2'b00;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ev_if.ev_ready = 1'b0;
        #12;
        checks++; if (cnt111 !== 8'd0) begin errors++; $display("FAIL reset_cnt111 got %0d want 0", cnt111); end
        checks++; if (cnt001 !== 8'd0) begin errors++; $display("FAIL reset_cnt001 got %0d want 0", cnt001); end
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %b want 0", ev_if.ev_valid); end
        checks++; if (ev_if.ev_data !== 7'h00) begin errors++; $display("FAIL reset_ev_data got %h want 00", ev_if.ev_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tb_ts = '0;
    endtask

    task automatic test_basic();
        enable = 1'b1;
        match  = 2'b00;
        ev_if.ev_ready = 1'b0;
        while (tb_ts != 6'd3) tick();
        match = 2'b10;
        tick();
        match = 2'b00;
        exp = {1'b1, 6'd3};
        checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_first got %b want 1", ev_if.ev_valid); end
        checks++; if (ev_if.ev_data !== exp) begin errors++; $display("FAIL basic_data_first got %h want %h", ev_if.ev_data, exp); end
        checks++; if (cnt111 !== 8'd1) begin errors++; $display("FAIL basic_cnt111 got %0d want 1", cnt111); end
        tick();
        match = 2'b01;
        tick();
        match = 2'b00;
        checks++; if (cnt001 !== 8'd1) begin errors++; $display("FAIL basic_cnt001 got %0d want 1", cnt001); end
        checks++; if (cnt111 !== 8'd1) begin errors++; $display("FAIL basic_cnt111_hold got %0d want 1", cnt111); end
        checks++; if (ev_if.ev_data !== exp) begin errors++; $display("FAIL basic_data_hold got %h want %h", ev_if.ev_data, exp); end
        ev_if.ev_ready = 1'b1;
        tick();
        exp = {1'b0, 6'd5};
        checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_second got %b want 1", ev_if.ev_valid); end
        checks++; if (ev_if.ev_data !== exp) begin errors++; $display("FAIL basic_data_second got %h want %h", ev_if.ev_data, exp); end
        tick();
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_empty got %b want 0", ev_if.ev_valid); end
        checks++; if (ev_if.ev_data !== 7'h00) begin errors++; $display("FAIL basic_data_empty got %h want 00", ev_if.ev_data); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [TS_W-1:0] t0;
        do_clear();
        enable = 1'b1;
        ev_if.ev_ready = 1'b0;
        t0 = tb_ts;
        match = 2'b01;
        repeat (5) tick();
        match = 2'b00;
        checks++; if (cnt001 !== 8'd5) begin errors++; $display("FAIL ovf_cnt001 got %0d want 5", cnt001); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = {1'b0, t0 + TS_W'(i)};
            checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain_valid[%0d] got %b want 1", i, ev_if.ev_valid); end
            checks++; if (ev_if.ev_data !== exp) begin errors++; $display("FAIL ovf_drain_data[%0d] got %h want %h", i, ev_if.ev_data, exp); end
            tick();
        end
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain_end got %b want 0", ev_if.ev_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_clear();
        enable = 1'b1;
        ev_if.ev_ready = 1'b0;
        match = 2'b01;
        repeat (4) tick();
        ev_if.ev_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exp = {1'b0, TS_W'(i)};
            checks++; if (ev_if.ev_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", i, ev_if.ev_valid); end
            checks++; if (ev_if.ev_data !== exp) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, ev_if.ev_data, exp); end
            tick();
        end
        match = 2'b00;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got %b want 0", overflow); end
        checks++; if (cnt001 !== 8'd24) begin errors++; $display("FAIL b2b_cnt001 got %0d want 24", cnt001); end
        for (int i = 0; i < 4; i++) begin
            exp = {1'b0, TS_W'(20 + i)};
            checks++; if (ev_if.ev_data !== exp) begin errors++; $display("FAIL b2b_tail[%0d] got %h want %h", i, ev_if.ev_data, exp); end
            tick();
        end
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", ev_if.ev_valid); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_saturate();
        logic [TS_W-1:0] t;
        do_clear();
        enable = 1'b1;
        ev_if.ev_ready = 1'b1;
        match = 2'b10;
        for (int i = 0; i < 300; i++) begin
            t = tb_ts;
            tick();
            exp = {1'b1, t};
            checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== exp) begin
                errors++; $display("FAIL sat_record[%0d] got %b/%h want 1/%h", i, ev_if.ev_valid, ev_if.ev_data, exp);
            end
            if (i == 254) begin
                checks++; if (cnt111 !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d want 255", cnt111); end
            end
        end
        match = 2'b00;
        checks++; if (cnt111 !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d want 255", cnt111); end
        checks++; if (cnt001 !== 8'd0) begin errors++; $display("FAIL sat_cnt001 got %0d want 0", cnt001); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sat_overflow got %b want 0", overflow); end
        tick();
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL sat_empty got %b want 0", ev_if.ev_valid); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_illegal();
        do_clear();
        enable = 1'b1;
        ev_if.ev_ready = 1'b0;
        match = 2'b10;
        tick();
        match = 2'b11;
        tick();
        match = 2'b00;
        exp = {1'b1, 6'd0};
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", illegal); end
        checks++; if (cnt111 !== 8'd1 || cnt001 !== 8'd0) begin errors++; $display("FAIL ill_counts got %0d/%0d want 1/0", cnt111, cnt001); end
        checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== exp) begin errors++; $display("FAIL ill_fifo got %b/%h want 1/%h", ev_if.ev_valid, ev_if.ev_data, exp); end
        enable = 1'b0;
        match = 2'b10;
        tick();
        match = 2'b00;
        enable = 1'b1;
        checks++; if (cnt111 !== 8'd1) begin errors++; $display("FAIL dis_cnt111 got %0d want 1", cnt111); end
        checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b want 1", illegal); end
        ev_if.ev_ready = 1'b1;
        tick();
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL dis_no_record got %b want 0", ev_if.ev_valid); end
        ev_if.ev_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clear();
        enable = 1'b1;
        ev_if.ev_ready = 1'b0;
        match = 2'b01;
        tick();
        match = 2'b11;
        tick();
        match = 2'b01;
        tick();
        match = 2'b00;
        checks++; if (ev_if.ev_valid !== 1'b1 || illegal !== 1'b1 || cnt001 !== 8'd2) begin
            errors++; $display("FAIL arst_setup got %b/%b/%0d want 1/1/2", ev_if.ev_valid, illegal, cnt001);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (cnt001 !== 8'd0) begin errors++; $display("FAIL arst_cnt001 got %0d want 0", cnt001); end
        checks++; if (ev_if.ev_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", ev_if.ev_valid); end
        checks++; if (ev_if.ev_data !== 7'h00) begin errors++; $display("FAIL arst_data got %h want 00", ev_if.ev_data); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL arst_illegal got %b want 0", illegal); end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tb_ts = '0;
    endtask

    task automatic test_clear_event();
        enable = 1'b1;
        ev_if.ev_ready = 1'b0;
        match = 2'b11;
        tick();
        match = 2'b01;
        repeat (5) tick();
        checks++; if (overflow !== 1'b1 || illegal !== 1'b1) begin errors++; $display("FAIL clr_setup got %b/%b want 1/1", overflow, illegal); end
        clear = 1'b1;
        match = 2'b10;
        tick();
        clear = 1'b0;
        match = 2'b00;
        checks++; if (cnt111 !== 8'd0 || cnt001 !== 8'd0) begin errors++; $display("FAIL clr_counts got %0d/%0d want 0/0", cnt111, cnt001); end
        checks++; if (ev_if.ev_valid !== 1'b0 || ev_if.ev_data !== 7'h00) begin errors++; $display("FAIL clr_fifo got %b/%h want 0/00", ev_if.ev_valid, ev_if.ev_data); end
        checks++; if (overflow !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL clr_flags got %b/%b want 0/0", overflow, illegal); end
        match = 2'b10;
        tick();
        match = 2'b00;
        exp = {1'b1, 6'd0};
        checks++; if (ev_if.ev_valid !== 1'b1 || ev_if.ev_data !== exp) begin errors++; $display("FAIL clr_ts_restart got %b/%h want 1/%h", ev_if.ev_valid, ev_if.ev_data, exp); end
        checks++; if (cnt111 !== 8'd1) begin errors++; $display("FAIL clr_cnt_restart got %0d want 1", cnt111); end
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_saturate();
        test_illegal();
        test_async_reset();
        test_clear_event();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
